// File: rtl/param_data_memory_if.sv
// Request/response bus between a load/store unit (master) and param_data_memory (slave).
// parFlip exists only when DMEM_PARITY_EN is defined.
interface param_data_memory_if #(
    parameter int ADDR_W = 32
);
    logic              reqValid;
    logic              reqReady;
    logic              reqWrite;
    logic [1:0]        reqSize;
    logic              reqSigned;
    logic [ADDR_W-1:0] reqAdr;
    logic [31:0]       reqWData;
`ifdef DMEM_PARITY_EN
    logic              parFlip;
`endif
    logic              rspValid;
    logic              rspReady;
    logic [31:0]       rspRData;
    logic              rspErr;

    modport master (
`ifdef DMEM_PARITY_EN
        output parFlip,
`endif
        output reqValid, reqWrite, reqSize, reqSigned, reqAdr, reqWData, rspReady,
        input  reqReady, rspValid, rspRData, rspErr
    );

    modport slave (
`ifdef DMEM_PARITY_EN
        input  parFlip,
`endif
        input  reqValid, reqWrite, reqSize, reqSigned, reqAdr, reqWData, rspReady,
        output reqReady, rspValid, rspRData, rspErr
    );
endinterface

// File: rtl/param_data_memory.sv
// Byte-addressable little-endian data memory with fixed-latency valid/ready request/response.
// Optional per-byte even parity is enabled by defining DMEM_PARITY_EN.
module param_data_memory #(
    parameter int                ADDR_W      = 32,
    parameter int                DEPTH_BYTES = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADR    = '0,
    parameter int                LATENCY     = 2
) (
    input  logic                 clk,
    input  logic                 rstN,
    param_data_memory_if.slave   bus,
    output logic                 busy,
    output logic [1:0]           dbgState
);
    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // the response side keeps rspValid, rspRData and rspErr stable until that edge.
    localparam int DEPTH_WORDS = DEPTH_BYTES / 4;
    localparam int WIDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W       = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } stateT;

    stateT              state, nextState;
    logic [CNT_W-1:0]   count;
    logic               writeQ, signedQ;
    logic [1:0]         sizeQ;
    logic [ADDR_W-1:0]  adrQ;
    logic [31:0]        wDataQ;
    logic [31:0]        rspDataQ;
    logic               rspErrQ;

    logic               accept, commit, doWrite;
    logic               cWrite, cSigned;
    logic [1:0]         cSize;
    logic [ADDR_W-1:0]  cAdr, offset;
    logic [31:0]        cWData;
    logic [ADDR_W:0]    endOff;
    logic [2:0]         nBytes;
    logic               accErr, loadErr;
    logic [WIDX_W-1:0]  wIdx;
    logic [1:0]         lane;
    logic [3:0]         byteEn;
    logic [31:0]        laneData, rdWord, rdShift, loadData;

`ifdef DMEM_PARITY_EN
    logic [31:0] mem [DEPTH_WORDS] = '{default: '0};
    logic [3:0]  par [DEPTH_WORDS] = '{default: '0};
    logic        parFlipQ, cParFlip, parErr;
    logic [3:0]  parCalc, parNew;
`else
    logic [31:0] mem [DEPTH_WORDS];
`endif

    assign bus.reqReady = rstN && (state == IDLE);
    assign bus.rspValid = (state == RESP);
    assign bus.rspRData = rspDataQ;
    assign bus.rspErr   = rspErrQ;
    assign busy         = (state != IDLE);
    assign dbgState     = state;
    assign accept       = bus.reqValid && bus.reqReady;

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (accept) nextState = (LATENCY == 1) ? RESP : WAIT;
            WAIT:    if (count == '0) nextState = RESP;
            RESP:    if (bus.rspReady) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // With LATENCY==1 the commit edge is the acceptance edge, so use the live request.
    assign commit   = (nextState == RESP) && (state != RESP);
    assign cWrite   = (state == IDLE) ? bus.reqWrite  : writeQ;
    assign cSize    = (state == IDLE) ? bus.reqSize   : sizeQ;
    assign cSigned  = (state == IDLE) ? bus.reqSigned : signedQ;
    assign cAdr     = (state == IDLE) ? bus.reqAdr    : adrQ;
    assign cWData   = (state == IDLE) ? bus.reqWData  : wDataQ;

    assign offset   = cAdr - BASE_ADR;
    assign endOff   = {1'b0, offset} + (ADDR_W+1)'(nBytes);
    assign accErr   = (cSize == 2'b11)
                   || (cSize == 2'b01 && cAdr[0])
                   || (cSize == 2'b10 && cAdr[1:0] != 2'b00)
                   || (endOff > (ADDR_W+1)'(DEPTH_BYTES));
    assign wIdx     = offset[WIDX_W+1:2];
    assign lane     = offset[1:0];
    assign doWrite  = commit && cWrite && !accErr;

    always_comb begin
        nBytes   = 3'd4;
        byteEn   = 4'b0000;
        laneData = cWData;
        case (cSize)
            2'b00: begin
                nBytes   = 3'd1;
                byteEn   = 4'b0001 << lane;
                laneData = {4{cWData[7:0]}};
            end
            2'b01: begin
                nBytes   = 3'd2;
                byteEn   = 4'b0011 << lane;
                laneData = {2{cWData[15:0]}};
            end
            2'b10:   byteEn = 4'b1111;
            default: byteEn = 4'b0000;
        endcase
    end

    // Every legal access lies inside one aligned word, so read the word and shift the lane down.
    assign rdWord  = mem[wIdx];
    assign rdShift = rdWord >> {lane, 3'b000};

    always_comb begin
        case (cSize)
            2'b00:   loadData = {{24{cSigned & rdShift[7]}},  rdShift[7:0]};
            2'b01:   loadData = {{16{cSigned & rdShift[15]}}, rdShift[15:0]};
            default: loadData = rdShift;
        endcase
    end

`ifdef DMEM_PARITY_EN
    assign cParFlip = (state == IDLE) ? bus.parFlip : parFlipQ;
    always_comb begin
        parCalc = '0;
        parNew  = '0;
        for (int i = 0; i < 4; i++) begin
            parCalc[i] = ^rdWord[8*i +: 8];
            parNew[i]  = (^laneData[8*i +: 8]) ^ cParFlip;
        end
    end
    assign parErr  = |((par[wIdx] ^ parCalc) & byteEn);
    assign loadErr = accErr || (!cWrite && parErr);

    always_ff @(posedge clk) begin
        if (doWrite) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) par[wIdx][i] <= parNew[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)       parFlipQ <= 1'b0;
        else if (accept) parFlipQ <= bus.parFlip;
    end
`else
    assign loadErr = accErr;
`endif

    always_ff @(posedge clk) begin
        if (doWrite) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) mem[wIdx][8*i +: 8] <= laneData[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= IDLE;
            count    <= '0;
            writeQ   <= 1'b0;
            sizeQ    <= 2'b00;
            signedQ  <= 1'b0;
            adrQ     <= '0;
            wDataQ   <= '0;
            rspDataQ <= '0;
            rspErrQ  <= 1'b0;
        end else begin
            state <= nextState;
            if (accept) begin
                writeQ  <= bus.reqWrite;
                sizeQ   <= bus.reqSize;
                signedQ <= bus.reqSigned;
                adrQ    <= bus.reqAdr;
                wDataQ  <= bus.reqWData;
                count   <= CNT_W'(LATENCY - 1);
            end else if (state == WAIT && count != '0) begin
                count <= count - 1'b1;
            end
            if (commit) begin
                rspDataQ <= (accErr || cWrite) ? 32'h0 : loadData;
                rspErrQ  <= loadErr;
            end
        end
    end
endmodule

// File: tb/tb_param_data_memory.sv
// Directed bench for param_data_memory: byte-array reference model, response scoreboard,
// latency / hold / mid-operation reset checks. Parity checks run when DMEM_PARITY_EN is defined.
module tb_param_data_memory;
  localparam int          ADDR_W = 32;
  localparam int          DEPTH  = 4096;
  localparam int          LAT    = 2;
  localparam logic [31:0] BASE   = 32'h0;

  logic       clk = 1'b0;
  logic       rstN;
  logic       busy;
  logic [1:0] dbg_state;

  param_data_memory_if #(.ADDR_W(ADDR_W)) bus ();

  param_data_memory #(
    .ADDR_W(ADDR_W), .DEPTH_BYTES(DEPTH), .BASE_ADR(BASE), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rstN(rstN), .bus(bus.slave), .busy(busy), .dbgState(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [32:0] exp_q[$];
  logic [32:0] cmp_e;
  logic [7:0]  model_mem [DEPTH];
  logic        flip_mem  [DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: returns {err, data} for one access and applies stores.
  function automatic logic [32:0] model_access(input logic w, input logic [1:0] sz, input logic sg,
                                               input logic [31:0] adr, input logic [31:0] wd,
                                               input logic flip);
    logic [31:0] off;
    int          nb;
    logic        err;
    logic        perr;
    logic [31:0] v;
    off = adr - BASE;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err = (sz == 2'd3) || (sz == 2'd1 && adr % 2 != 0) || (sz == 2'd2 && adr % 4 != 0)
       || (longint'(off) + nb > DEPTH);
    if (err) return {1'b1, 32'h0};
    if (w) begin
      for (int i = 0; i < nb; i++) begin
        model_mem[off + i] = wd[8*i +: 8];
        flip_mem[off + i]  = flip;
      end
      return {1'b0, 32'h0};
    end
    v    = 32'h0;
    perr = 1'b0;
    for (int i = 0; i < nb; i++) begin
      v    = v | (32'(model_mem[off + i]) << (8 * i));
      perr = perr | flip_mem[off + i];
    end
    if (sg && nb == 1 && v >= 32'h80)   v = v - 32'h100;
    if (sg && nb == 2 && v >= 32'h8000) v = v - 32'h10000;
    return {perr, v};
  endfunction

  // scoreboard: compare every accepted response against the queued expectation
  always @(negedge clk) begin
    if (rstN && bus.rspValid && bus.rspReady) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rsp_unexpected: got data 0x%08h with empty expectation queue", bus.rspRData);
      end else begin
        cmp_e = exp_q.pop_front();
        check("rsp_data", bus.rspRData, cmp_e[31:0]);
        check("rsp_err",  32'(bus.rspErr), 32'(cmp_e[32]));
      end
    end
  end

  task automatic drive_req(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] adr, input logic [31:0] wd, input logic flip);
    int cyc;
    @(negedge clk);
    bus.reqValid  = 1'b1;
    bus.reqWrite  = w;
    bus.reqSize   = sz;
    bus.reqSigned = sg;
    bus.reqAdr    = adr;
    bus.reqWData  = wd;
`ifdef DMEM_PARITY_EN
    bus.parFlip   = flip;
`endif
    cyc = 0;
    while (!bus.reqReady && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("req_ready", 32'(bus.reqReady), 32'd1);
    @(posedge clk);
  endtask

  // One complete transaction; ed/ee are the hand-computed expectations for this vector.
  task automatic run(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] adr,
                     input logic [31:0] wd, input logic [31:0] ed, input logic ee,
                     input int hold, input logic flip);
    logic [32:0] m;
    logic [31:0] d0;
    int          cyc;
    drive_req(w, sz, sg, adr, wd, flip);
    m = model_access(w, sz, sg, adr, wd, flip);
    check("model_pin_data", m[31:0], ed);
    check("model_pin_err", 32'(m[32]), 32'(ee));
    exp_q.push_back(m);
    #1 bus.reqValid = 1'b0;
    cyc = 0;
    while (!bus.rspValid && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("latency", 32'(cyc), 32'(LAT));
    d0 = bus.rspRData;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(bus.rspValid), 32'd1);
      check("hold_data", bus.rspRData, d0);
      check("hold_req_ready", 32'(bus.reqReady), 32'd0);
    end
    bus.rspReady = 1'b1;
    @(posedge clk);
    #1 bus.rspReady = 1'b0;
    check("idle_req_ready", 32'(bus.reqReady), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_rsp_valid", 32'(bus.rspValid), 32'd0);
  endtask

  // Store accepted, then reset pulled during WAIT: nothing is committed.
  task automatic run_abort(input logic [31:0] adr, input logic [31:0] wd);
    drive_req(1'b1, 2'd2, 1'b0, adr, wd, 1'b0);
    #1 bus.reqValid = 1'b0;
    @(posedge clk);
    #1 rstN = 1'b0;
    #1;
    check("abort_req_ready", 32'(bus.reqReady), 32'd0);
    check("abort_rsp_valid", 32'(bus.rspValid), 32'd0);
    check("abort_rsp_data", bus.rspRData, 32'h0);
    check("abort_rsp_err", 32'(bus.rspErr), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    check("abort_ready_after", 32'(bus.reqReady), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) flip_mem[i] = 1'b0;
    rstN          = 1'b0;
    bus.reqValid  = 1'b0;
    bus.reqWrite  = 1'b0;
    bus.reqSize   = 2'd0;
    bus.reqSigned = 1'b0;
    bus.reqAdr    = '0;
    bus.reqWData  = '0;
    bus.rspReady  = 1'b0;
`ifdef DMEM_PARITY_EN
    bus.parFlip   = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(bus.reqReady), 32'd0);
    check("rst_rsp_valid", 32'(bus.rspValid), 32'd0);
    check("rst_rsp_data", bus.rspRData, 32'h0);
    check("rst_rsp_err", 32'(bus.rspErr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    #1 check("ready_after_reset", 32'(bus.reqReady), 32'd1);

    //  w     sz     sg    adr            wdata          exp data       err  hold flip
    run(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 0, 1'b0);
    run(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 5, 1'b0);
    run(1'b0, 2'd0, 1'b1, 32'h0000_0013, 32'h0,         32'hFFFF_FFDE, 1'b0, 0, 1'b0);
    run(1'b0, 2'd0, 1'b0, 32'h0000_0013, 32'h0,         32'h0000_00DE, 1'b0, 0, 1'b0);
    run(1'b0, 2'd1, 1'b1, 32'h0000_0010, 32'h0,         32'hFFFF_BEEF, 1'b0, 0, 1'b0);
    run(1'b0, 2'd1, 1'b0, 32'h0000_0012, 32'h0,         32'h0000_DEAD, 1'b0, 0, 1'b0);
    run(1'b1, 2'd0, 1'b0, 32'h0000_0011, 32'h0000_0055, 32'h0000_0000, 1'b0, 0, 1'b0);
    run(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_55EF, 1'b0, 0, 1'b0);
    run(1'b0, 2'd1, 1'b0, 32'h0000_0011, 32'h0,         32'h0000_0000, 1'b1, 0, 1'b0);
    run(1'b0, 2'd2, 1'b0, 32'h0000_0012, 32'h0,         32'h0000_0000, 1'b1, 0, 1'b0);
    run(1'b0, 2'd3, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_0000, 1'b1, 0, 1'b0);
    run(1'b0, 2'd2, 1'b0, 32'h0000_0FFE, 32'h0,         32'h0000_0000, 1'b1, 0, 1'b0);
    run(1'b1, 2'd1, 1'b0, 32'h0000_0011, 32'h0000_1234, 32'h0000_0000, 1'b1, 0, 1'b0);
    run(1'b1, 2'd2, 1'b0, 32'h0000_0FFE, 32'h1234_5678, 32'h0000_0000, 1'b1, 0, 1'b0);
    run(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_55EF, 1'b0, 0, 1'b0);
    run(1'b1, 2'd2, 1'b0, 32'h0000_0FFC, 32'hA5A5_0F0F, 32'h0000_0000, 1'b0, 0, 1'b0);
    run(1'b0, 2'd2, 1'b0, 32'h0000_0FFC, 32'h0,         32'hA5A5_0F0F, 1'b0, 0, 1'b0);
    run(1'b0, 2'd0, 1'b1, 32'h0000_0FFF, 32'h0,         32'hFFFF_FFA5, 1'b0, 0, 1'b0);
    run(1'b0, 2'd1, 1'b1, 32'h0000_0FFC, 32'h0,         32'h0000_0F0F, 1'b0, 0, 1'b0);
    run(1'b0, 2'd0, 1'b0, 32'h0000_1000, 32'h0,         32'h0000_0000, 1'b1, 0, 1'b0);
    run(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0000_0000, 1'b1, 0, 1'b0);
    run(1'b1, 2'd2, 1'b0, 32'h0000_0020, 32'h1122_3344, 32'h0000_0000, 1'b0, 0, 1'b0);
    run(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_55EF, 1'b0, 0, 1'b0);
    run_abort(32'h0000_0020, 32'hCAFE_F00D);
    run(1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0,         32'h1122_3344, 1'b0, 0, 1'b0);
    run(1'b1, 2'd1, 1'b0, 32'h0000_0022, 32'hFFFF_8001, 32'h0000_0000, 1'b0, 0, 1'b0);
    run(1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0,         32'h8001_3344, 1'b0, 0, 1'b0);
`ifdef DMEM_PARITY_EN
    run(1'b1, 2'd2, 1'b0, 32'h0000_0030, 32'h0102_0304, 32'h0000_0000, 1'b0, 0, 1'b1);
    run(1'b0, 2'd2, 1'b0, 32'h0000_0030, 32'h0,         32'h0102_0304, 1'b1, 0, 1'b0);
    run(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_55EF, 1'b0, 0, 1'b0);
`endif

    repeat (2) @(posedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
